// File: rtl/arm_pkg.sv
// Shared fetch-stage types and constants.
package arm_pkg;

  typedef enum logic {
    S_REQ,
    S_HELD
  } fetch_state_t;

  localparam int unsigned PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble.
module if_id_reg #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               hold,
  input  logic               load,
  input  logic [ADDR_W-1:0]  pc_d,
  input  logic [INSTR_W-1:0] instr_d,
  output logic [ADDR_W-1:0]  pc_q,
  output logic [INSTR_W-1:0] instr_q,
  output logic               valid_q
);

  import arm_pkg::*;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= INSTR_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (flush) begin
      pc_q    <= '0;
      instr_q <= INSTR_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (hold) begin
      pc_q    <= pc_q;
      instr_q <= instr_q;
      valid_q <= valid_q;
    end else if (load) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= 1'b1;
    end else begin
      pc_q    <= '0;
      instr_q <= INSTR_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues req/ready fetches, feeds the IF/ID register.
module if_fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        PC_STEP  = arm_pkg::PC_STEP,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instruction,
  output logic               valid
);

  import arm_pkg::*;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  logic [ADDR_W-1:0]  redirect_tgt;
  logic               redirect_pend;
  logic [INSTR_W-1:0] skid_instr;
  logic               accept_word;
  logic               ifid_load;
  logic [INSTR_W-1:0] ifid_instr;

  assign pc_next   = pc + STEP;
  assign imem_req  = rst && (state == S_REQ);
  assign imem_addr = pc;

  // Both the live word and the skid word belong to the current pc, so pc+STEP serves either.
  assign accept_word = (state == S_REQ) && imem_ready && !redirect_pend;
  assign ifid_load   = (state == S_HELD) || accept_word;
  assign ifid_instr  = (state == S_HELD) ? skid_instr : imem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      redirect_pend <= 1'b0;
      redirect_tgt  <= '0;
      skid_instr    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (branch_taken) begin
            // Address must stay put until the in-flight fetch completes.
            if (imem_ready) begin
              pc            <= branch_addr;
              redirect_pend <= 1'b0;
            end else begin
              redirect_pend <= 1'b1;
              redirect_tgt  <= branch_addr;
            end
          end else if (imem_ready) begin
            if (redirect_pend) begin
              pc            <= redirect_tgt;
              redirect_pend <= 1'b0;
            end else if (freeze) begin
              skid_instr <= imem_rdata;
              state      <= S_HELD;
            end else begin
              pc <= pc_next;
            end
          end
        end
        S_HELD: begin
          if (branch_taken) begin
            pc    <= branch_addr;
            state <= S_REQ;
          end else if (!freeze) begin
            pc    <= pc_next;
            state <= S_REQ;
          end
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush   (branch_taken),
    .hold    (freeze),
    .load    (ifid_load),
    .pc_d    (pc_next),
    .instr_d (ifid_instr),
    .pc_q    (pc_out),
    .instr_q (instruction),
    .valid_q (valid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: memory words derive from their address.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_fetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .PC_STEP  (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .pc_out       (pc_out),
    .instruction  (instruction),
    .valid        (valid)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] a);
    exp_t e;
    e.pc    = a + 32'd4;
    e.instr = mem_word(a);
    sb.push_back(e);
  endtask

  // One clock; pops the scoreboard whenever IF/ID was free to load a new word.
  task automatic step(input string tag);
    logic fr;
    logic br;
    exp_t e;
    fr = freeze;
    br = branch_taken;
    @(posedge clk);
    #1;
    if (br) begin
      check_val({tag, "_flush_valid"}, {31'b0, valid}, 32'd0);
    end else if (!fr && valid) begin
      if (sb.size() == 0) begin
        check_val({tag, "_unexpected_instr"}, pc_out, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_val({tag, "_pc_out"}, pc_out, e.pc);
        check_val({tag, "_instr"}, instruction, e.instr);
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem_ready   = 1'b0;

    #12;
    check_val("rst_req", {31'b0, imem_req}, 32'd0);
    check_val("rst_valid", {31'b0, valid}, 32'd0);
    check_val("rst_pc_out", pc_out, 32'd0);
    check_val("rst_instr", instruction, 32'd0);
    rst = 1'b1;
    #1;
    check_val("rel_req", {31'b0, imem_req}, 32'd1);
    check_val("rel_addr", imem_addr, 32'd0);

    // Zero-wait memory: one instruction per clock.
    imem_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      check_val("t1_addr", imem_addr, 32'(4 * i));
      expect_word(32'(4 * i));
      step("t1");
    end

    // Three wait states: address stable, bubbles out.
    imem_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      check_val("t2_wait_addr", imem_addr, 32'd32);
      check_val("t2_wait_req", {31'b0, imem_req}, 32'd1);
      step("t2");
      check_val("t2_bubble", {31'b0, valid}, 32'd0);
    end
    imem_ready = 1'b1;
    expect_word(32'd32);
    step("t2");

    // Freeze while the next word returns: skid, req drops, IF/ID held.
    freeze = 1'b1;
    step("t3");
    check_val("t3_req_held", {31'b0, imem_req}, 32'd0);
    check_val("t3_hold_pc", pc_out, 32'd36);
    check_val("t3_hold_instr", instruction, mem_word(32'd32));
    imem_ready = 1'b0;
    step("t3");
    check_val("t3_req_held2", {31'b0, imem_req}, 32'd0);
    check_val("t3_hold_valid", {31'b0, valid}, 32'd1);
    check_val("t3_addr_held", imem_addr, 32'd36);
    freeze = 1'b0;
    expect_word(32'd36);
    step("t3");
    check_val("t3_next_addr", imem_addr, 32'd40);
    check_val("t3_next_req", {31'b0, imem_req}, 32'd1);

    // Branch with ready in the same cycle.
    imem_ready   = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step("t4");
    branch_taken = 1'b0;
    check_val("t4_addr", imem_addr, 32'h100);
    expect_word(32'h100);
    step("t4");
    imem_ready = 1'b0;

    // Branch mid-wait; second branch overwrites the pending target.
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    step("t5");
    branch_addr  = 32'h200;
    step("t5");
    branch_taken = 1'b0;
    check_val("t5_addr_stable", imem_addr, 32'h104);
    step("t5");
    check_val("t5_bubble", {31'b0, valid}, 32'd0);
    imem_ready = 1'b1;
    step("t5");
    check_val("t5_discard", {31'b0, valid}, 32'd0);
    check_val("t5_addr", imem_addr, 32'h200);
    expect_word(32'h200);
    step("t5");

    // Branch and freeze together: flush wins in both states.
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h400;
    step("t6");
    check_val("t6_req", {31'b0, imem_req}, 32'd1);
    check_val("t6_addr", imem_addr, 32'h400);
    branch_taken = 1'b0;
    step("t6");
    check_val("t6_held_req", {31'b0, imem_req}, 32'd0);
    imem_ready   = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h500;
    step("t6");
    check_val("t6_held_br_req", {31'b0, imem_req}, 32'd1);
    check_val("t6_held_br_addr", imem_addr, 32'h500);
    branch_taken = 1'b0;
    freeze       = 1'b0;

    // Asynchronous reset in the middle of a wait.
    step("t6");
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_rst_req", {31'b0, imem_req}, 32'd0);
    check_val("t6_rst_valid", {31'b0, valid}, 32'd0);
    check_val("t6_rst_pc_out", pc_out, 32'd0);
    check_val("t6_rst_instr", instruction, 32'd0);
    check_val("t6_rst_addr", imem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t6_rel_req", {31'b0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    expect_word(32'd0);
    step("t6");

    // PC wraps modulo 2^32.
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    step("wrap");
    branch_taken = 1'b0;
    check_val("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    expect_word(32'hFFFF_FFFC);
    step("wrap");
    check_val("wrap_next_addr", imem_addr, 32'd0);
    imem_ready = 1'b0;
    step("wrap");

    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
